key_debounce: RTL and testbench

- Debounce filter for mechanical push-buttons and switches, directly upstream of the rising-edge detector.
- Synchronises the raw asynchronous pad input into sys_clk with a 2-FF synchroniser.
- Applies optional polarity inversion, then qualifies the level with a stable-time counter.
- Emits a clean, glitch-free level (key_o) that drives the edge detector's data input.

---
 rtl/key_debounce_if.sv | 21 ++
 rtl/key_debounce.sv | 126 ++++++++++++
 tb/tb_key_debounce.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/key_debounce_if.sv
// Push-button bus between the pad side and the debounced-level consumer.
interface key_debounce_if;
    logic key_i;
    logic key_o;
    logic busy_o;
    logic bounce_o;

    modport master (
        output key_i,
        input  key_o,
        input  busy_o,
        input  bounce_o
    );

    modport slave (
        input  key_i,
        output key_o,
        output busy_o,
        output bounce_o
    );
endinterface

// File: rtl/key_debounce.sv
// Push-button debounce: 2-FF synchroniser, optional inversion, then a stable-time
// qualifying FSM producing a clean pressed level for the downstream edge detector.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    key_debounce_if.slave key_bus
);

    if (DEBOUNCE_CYCLES < 1 || (CNT_W < 32 && DEBOUNCE_CYCLES >= (32'd1 << CNT_W)))
    begin : g_bad_cycles
        $error("key_debounce: DEBOUNCE_CYCLES must be in 1 .. 2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam bit               Direct  = (DEBOUNCE_CYCLES == 1);

    typedef enum logic [1:0] {
        StUp,
        StUpChk,
        StDn,
        StDnChk
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ff1_q;
    logic             ff2_q;
    logic             key_q;
    logic             busy_q;
    logic             bounce_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ff1_q    <= 1'b0;
            ff2_q    <= 1'b0;
            state_q  <= StUp;
            cnt_q    <= '0;
            key_q    <= 1'b0;
            busy_q   <= 1'b0;
            bounce_q <= 1'b0;
        end else begin
            ff1_q    <= key_bus.key_i ^ KEY_ACTIVE_LOW;
            ff2_q    <= ff1_q;
            bounce_q <= 1'b0;
            // key_q/busy_q are updated alongside state_q so they always decode the new state.
            case (state_q)
                StUp: begin
                    if (ff2_q) begin
                        if (Direct) begin
                            state_q <= StDn;
                            key_q   <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= StUpChk;
                            busy_q  <= 1'b1;
                            cnt_q   <= CNT_W'(1);
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end
                StUpChk: begin
                    // A contrary sample wins even when the window completes on this edge.
                    if (!ff2_q) begin
                        state_q  <= StUp;
                        busy_q   <= 1'b0;
                        bounce_q <= 1'b1;
                        cnt_q    <= '0;
                    end else if (cnt_q == LastCnt) begin
                        state_q <= StDn;
                        key_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDn: begin
                    if (!ff2_q) begin
                        if (Direct) begin
                            state_q <= StUp;
                            key_q   <= 1'b0;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= StDnChk;
                            busy_q  <= 1'b1;
                            cnt_q   <= CNT_W'(1);
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end
                StDnChk: begin
                    if (ff2_q) begin
                        state_q  <= StDn;
                        busy_q   <= 1'b0;
                        bounce_q <= 1'b1;
                        cnt_q    <= '0;
                    end else if (cnt_q == LastCnt) begin
                        state_q <= StUp;
                        key_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StUp;
                    key_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign key_bus.key_o    = key_q;
    assign key_bus.busy_o   = busy_q;
    assign key_bus.bounce_o = bounce_q;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: directed stimulus queues expected output events,
// a negedge monitor pops and compares every key_o/busy_o change and bounce_o cycle.
module tb_key_debounce;

    localparam int KindKey    = 0;
    localparam int KindBusy   = 1;
    localparam int KindBounce = 2;

    typedef struct {
        int   cyc;
        int   kind;
        logic val;
    } ev_t;

    logic sys_clk = 1'b0;
    logic rst_a;
    logic rst_b;
    logic mon_en;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   bounces_a = 0;
    ev_t  exp_a[$];
    ev_t  exp_b[$];
    logic pk_a, pb_a, pk_b, pb_b;

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    key_debounce_if bus_a ();
    key_debounce_if bus_b ();

    key_debounce #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3),
        .KEY_ACTIVE_LOW (1'b1)
    ) dut_a (
        .sys_clk(sys_clk),
        .sys_rst(rst_a),
        .key_bus(bus_a.slave)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(1),
        .CNT_W          (2),
        .KEY_ACTIVE_LOW (1'b0)
    ) dut_b (
        .sys_clk(sys_clk),
        .sys_rst(rst_b),
        .key_bus(bus_b.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push(input int d, input int c, input int kind, input logic val);
        ev_t e;
        e = '{cyc: c, kind: kind, val: val};
        if (d == 0) exp_a.push_back(e);
        else exp_b.push_back(e);
    endtask

    task automatic got_event(input int d, input int kind, input logic val);
        ev_t e;
        bit  empty;
        empty = (d == 0) ? (exp_a.size() == 0) : (exp_b.size() == 0);
        vectors++;
        if (empty) begin
            miscompares++;
            $display("FAIL dut%0d unexpected event: got kind=%0d val=%0b at cycle %0d, required none",
                     d, kind, val, cyc);
        end else begin
            if (d == 0) e = exp_a.pop_front();
            else e = exp_b.pop_front();
            if (e.kind != kind || e.val !== val || e.cyc != cyc) begin
                miscompares++;
                $display("FAIL dut%0d event: got kind=%0d val=%0b cycle=%0d, required kind=%0d val=%0b cycle=%0d",
                         d, kind, val, cyc, e.kind, e.val, e.cyc);
            end
        end
    endtask

    always @(negedge sys_clk) begin
        if (!mon_en) begin
            pk_a = bus_a.key_o;
            pb_a = bus_a.busy_o;
            pk_b = bus_b.key_o;
            pb_b = bus_b.busy_o;
        end else begin
            if (bus_a.key_o !== pk_a) begin
                got_event(0, KindKey, bus_a.key_o);
                pk_a = bus_a.key_o;
            end
            if (bus_a.busy_o !== pb_a) begin
                got_event(0, KindBusy, bus_a.busy_o);
                pb_a = bus_a.busy_o;
            end
            if (bus_a.bounce_o !== 1'b0) begin
                got_event(0, KindBounce, bus_a.bounce_o);
                bounces_a++;
            end
            if (bus_b.key_o !== pk_b) begin
                got_event(1, KindKey, bus_b.key_o);
                pk_b = bus_b.key_o;
            end
            if (bus_b.busy_o !== pb_b) begin
                got_event(1, KindBusy, bus_b.busy_o);
                pb_b = bus_b.busy_o;
            end
            if (bus_b.bounce_o !== 1'b0) got_event(1, KindBounce, bus_b.bounce_o);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Returns just after edge c, so a value driven now is sampled on edge c+1.
    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    initial begin
        int   e;
        int   r;
        int   b0;
        logic train [7];
        train = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        mon_en      = 1'b0;
        rst_a       = 1'b1;
        rst_b       = 1'b1;
        bus_a.key_i = 1'b1;
        bus_b.key_i = 1'b0;
        tick(3);
        rst_a  = 1'b0;
        rst_b  = 1'b0;
        mon_en = 1'b1;
        check("rst key_o a", bus_a.key_o, 0);
        check("rst busy_o a", bus_a.busy_o, 0);
        check("rst bounce_o a", bus_a.bounce_o, 0);
        check("rst key_o b", bus_b.key_o, 0);

        // Released key held for 20 cycles: no events at all.
        tick(20);
        check("idle key_o a", bus_a.key_o, 0);
        check("idle busy_o a", bus_a.busy_o, 0);
        check("idle bounce_o a", bus_a.bounce_o, 0);

        // Clean press, then clean release 20 edges later.
        e = cyc + 1;
        bus_a.key_i = 1'b0;
        push(0, e + 2, KindBusy, 1'b1);
        push(0, e + 5, KindKey, 1'b1);
        push(0, e + 5, KindBusy, 1'b0);
        wait_until(e + 10);
        check("pressed key_o a", bus_a.key_o, 1);
        check("pressed busy_o a", bus_a.busy_o, 0);
        wait_until(e + 19);
        push(0, e + 22, KindBusy, 1'b1);
        push(0, e + 25, KindKey, 1'b0);
        push(0, e + 25, KindBusy, 1'b0);
        bus_a.key_i = 1'b1;
        wait_until(e + 30);
        check("released key_o a", bus_a.key_o, 0);

        // Five presses of 3 synchronised samples: each aborts once, key_o stays low.
        b0 = bounces_a;
        for (int i = 0; i < 5; i++) begin
            e = cyc + 1;
            bus_a.key_i = 1'b0;
            push(0, e + 2, KindBusy, 1'b1);
            push(0, e + 5, KindBusy, 1'b0);
            push(0, e + 5, KindBounce, 1'b1);
            wait_until(e + 2);
            bus_a.key_i = 1'b1;
            wait_until(e + 7);
        end
        tick(5);
        check("short press bounce count", bounces_a - b0, 5);
        check("short press key_o a", bus_a.key_o, 0);

        // Bounce train; the second abort lands on the edge the count completes.
        e = cyc + 1;
        push(0, e + 2, KindBusy, 1'b1);
        push(0, e + 3, KindBusy, 1'b0);
        push(0, e + 3, KindBounce, 1'b1);
        push(0, e + 4, KindBusy, 1'b1);
        push(0, e + 7, KindBusy, 1'b0);
        push(0, e + 7, KindBounce, 1'b1);
        push(0, e + 8, KindBusy, 1'b1);
        push(0, e + 11, KindKey, 1'b1);
        push(0, e + 11, KindBusy, 1'b0);
        for (int k = 0; k < 7; k++) begin
            bus_a.key_i = train[k];
            tick(1);
        end
        wait_until(e + 15);
        check("train key_o a", bus_a.key_o, 1);

        // One-cycle reset while pressed: key_o drops, then requalifies.
        r = cyc + 1;
        push(0, r, KindKey, 1'b0);
        push(0, r + 3, KindBusy, 1'b1);
        push(0, r + 6, KindKey, 1'b1);
        push(0, r + 6, KindBusy, 1'b0);
        rst_a = 1'b1;
        tick(1);
        rst_a = 1'b0;
        check("reset forces key_o a", bus_a.key_o, 0);
        check("reset busy_o a", bus_a.busy_o, 0);
        wait_until(r + 10);
        check("repress key_o a", bus_a.key_o, 1);

        // DEBOUNCE_CYCLES=1, no inversion: two-edge latency, glitches pass through.
        e = cyc + 1;
        bus_b.key_i = 1'b1;
        push(1, e + 2, KindKey, 1'b1);
        wait_until(e + 9);
        push(1, e + 12, KindKey, 1'b0);
        push(1, e + 13, KindKey, 1'b1);
        bus_b.key_i = 1'b0;
        tick(1);
        bus_b.key_i = 1'b1;
        wait_until(e + 19);
        push(1, e + 22, KindKey, 1'b0);
        bus_b.key_i = 1'b0;
        wait_until(e + 29);
        push(1, e + 32, KindKey, 1'b1);
        push(1, e + 33, KindKey, 1'b0);
        bus_b.key_i = 1'b1;
        tick(1);
        bus_b.key_i = 1'b0;
        wait_until(e + 40);
        check("fast key_o b", bus_b.key_o, 0);
        check("fast busy_o b", bus_b.busy_o, 0);

        check("pending events a", exp_a.size(), 0);
        check("pending events b", exp_b.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
